ssio_rx_framer: RTL

Receive-side framer that sits directly downstream of the differential source-synchronous SDR input stage, in its recovered clock domain. It takes the captured 10-bit GMII-style word (8 data bits, data-valid, error), strips preamble/SFD, and delivers payload bytes as a non-backpressurable AXI-stream with tlast/tuser. It also produces per-frame status pulses.

---
 rtl/ssio_rx_framer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ssio_rx_framer.sv
// GMII-style receive framer: strips preamble/SFD and emits payload
// bytes as a non-backpressurable AXI-stream with per-frame status.
module ssio_rx_framer #(
  parameter int MAX_PREAMBLE_LEN = 7,
  parameter int MAX_FRAME_LEN    = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       stat_frame_good,
  output logic       stat_frame_bad,
  output logic       stat_preamble_err,
  output logic       stat_oversize
);

  localparam int PW = $clog2(MAX_PREAMBLE_LEN + 1);
  localparam int BW = $clog2(MAX_FRAME_LEN + 1);

  localparam logic [7:0] PRE_B = 8'h55;
  localparam logic [7:0] SFD_B = 8'hD5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_PAY,
    S_DROP
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic          err_q, err_d;
  logic [7:0]    hold_q, hold_d;
  logic          hvld_q, hvld_d;

  logic [7:0] tdata_q, tdata_d;
  logic       tvalid_q, tvalid_d;
  logic       tlast_q, tlast_d;
  logic       tuser_q, tuser_d;
  logic       good_q, good_d;
  logic       bad_q, bad_d;
  logic       perr_q, perr_d;
  logic       over_q, over_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_DROP;
      pre_cnt_q  <= '0;
      byte_cnt_q <= '0;
      err_q      <= 1'b0;
      hold_q     <= 8'h00;
      hvld_q     <= 1'b0;
      tdata_q    <= 8'h00;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      perr_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
      hvld_q     <= hvld_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      perr_q     <= perr_d;
      over_q     <= over_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    byte_cnt_d = byte_cnt_q;
    err_d      = err_q;
    hold_d     = hold_q;
    hvld_d     = hvld_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    tuser_d    = 1'b0;
    good_d     = 1'b0;
    bad_d      = 1'b0;
    perr_d     = 1'b0;
    over_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == PRE_B) begin
            state_d   = S_PRE;
            pre_cnt_d = PW'(1);
          end else begin
            state_d = S_DROP;
            perr_d  = 1'b1;
          end
        end
      end

      S_PRE: begin
        if (!gmii_rx_dv) begin
          state_d = S_IDLE;
          perr_d  = 1'b1;
        end else if (gmii_rx_er) begin
          state_d = S_DROP;
          perr_d  = 1'b1;
        end else if (gmii_rxd == PRE_B) begin
          if (pre_cnt_q == PW'(MAX_PREAMBLE_LEN)) begin
            state_d = S_DROP;
            perr_d  = 1'b1;
          end else begin
            pre_cnt_d = pre_cnt_q + PW'(1);
          end
        end else if (gmii_rxd == SFD_B) begin
          state_d    = S_PAY;
          byte_cnt_d = '0;
          err_d      = 1'b0;
          hvld_d     = 1'b0;
        end else begin
          state_d = S_DROP;
          perr_d  = 1'b1;
        end
      end

      S_PAY: begin
        if (!gmii_rx_dv) begin
          state_d = S_IDLE;
          hvld_d  = 1'b0;
          if (hvld_q) begin
            tdata_d  = hold_q;
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tuser_d  = err_q;
            good_d   = !err_q;
            bad_d    = err_q;
          end else begin
            bad_d = 1'b1;
          end
        end else if (byte_cnt_q == BW'(MAX_FRAME_LEN)) begin
          // Incoming byte is dropped; the held byte closes the frame as bad.
          state_d  = S_DROP;
          hvld_d   = 1'b0;
          tdata_d  = hold_q;
          tvalid_d = 1'b1;
          tlast_d  = 1'b1;
          tuser_d  = 1'b1;
          over_d   = 1'b1;
          bad_d    = 1'b1;
        end else begin
          hold_d = gmii_rxd;
          hvld_d = 1'b1;
          err_d  = err_q | gmii_rx_er;
          if (hvld_q) begin
            tdata_d  = hold_q;
            tvalid_d = 1'b1;
          end
          if (byte_cnt_q != {BW{1'b1}})
            byte_cnt_d = byte_cnt_q + BW'(1);
        end
      end

      S_DROP: begin
        if (!gmii_rx_dv)
          state_d = S_IDLE;
      end

      default: state_d = S_DROP;
    endcase
  end

  assign m_axis_tdata      = tdata_q;
  assign m_axis_tvalid     = tvalid_q;
  assign m_axis_tlast      = tlast_q;
  assign m_axis_tuser      = tuser_q;
  assign stat_frame_good   = good_q;
  assign stat_frame_bad    = bad_q;
  assign stat_preamble_err = perr_q;
  assign stat_oversize     = over_q;

endmodule
